// File: rtl/gsu_pc_sequencer_pkg.sv
// Shared GSU package: program-counter source encoding and default widths
// for the PC sequencer slice.
package gsu_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int LOOP_W_DEF      = 16;
  localparam int BR_W_DEF        = 8;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_JMP,
    SRC_RET,
    SRC_CALL,
    SRC_BR,
    SRC_LOOP,
    SRC_INC,
    SRC_KEEP
  } pc_src_e;

endpackage

// File: rtl/gsu_pc_sequencer_if.sv
// Decode-to-sequencer bundle: PC requests from decode and the sequencer status
// returned to it.
interface gsu_pc_sequencer_if
  import gsu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int LOOP_W      = LOOP_W_DEF,
  parameter int BR_W        = BR_W_DEF
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              hold;
  logic              pc_inc;
  logic              jmp_en;
  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] jmp_addr;
  logic              br_en;
  logic [BR_W-1:0]   br_off;
  logic              loop_load;
  logic [LOOP_W-1:0] loop_cnt_in;
  logic [ADDR_W-1:0] loop_tgt_in;
  logic              loop_en;
  logic              err_clr;
  logic [ADDR_W-1:0] pc;
  logic [LVL_W-1:0]  stk_level;
  logic              stk_ovf;
  logic              stk_unf;
  logic [LOOP_W-1:0] loop_cnt;
  logic              loop_zero;

  modport master (
    output hold, pc_inc, jmp_en, call_en, ret_en, jmp_addr, br_en, br_off,
           loop_load, loop_cnt_in, loop_tgt_in, loop_en, err_clr,
    input  pc, stk_level, stk_ovf, stk_unf, loop_cnt, loop_zero
  );

  modport slave (
    input  hold, pc_inc, jmp_en, call_en, ret_en, jmp_addr, br_en, br_off,
           loop_load, loop_cnt_in, loop_tgt_in, loop_en, err_clr,
    output pc, stk_level, stk_ovf, stk_unf, loop_cnt, loop_zero
  );

endinterface

// File: rtl/gsu_pc_sequencer_ret_stack.sv
// Return-address LIFO for the PC sequencer; push is ignored when full and
// pop when empty, so the caller only has to flag those cases.
module gsu_ret_stack
  import gsu_pkg::*;
#(
  parameter int W     = ADDR_W_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     top_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [LVL_W-1:0] level_q;

  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

  // Top of stack is the entry just below the fill level.
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i + 1) == level_q) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (LVL_W'(i) == level_q) mem_q[i] <= data_i;
      end
      level_q <= level_q + LVL_W'(1);
    end else if (pop_i && !empty_o) begin
      level_q <= level_q - LVL_W'(1);
    end
  end

endmodule

// File: rtl/gsu_pc_sequencer.sv
// GSU program-counter sequencer: one-cycle arbitration of jump/ret/call/branch/loop/inc.
// Hardware loop counter is present only when GSU_PC_LOOP_HW_EN is defined.
module gsu_pc_sequencer
  import gsu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int LOOP_W      = LOOP_W_DEF,
  parameter int BR_W        = BR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  gsu_pc_sequencer_if.slave   seq_if
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1, br_tgt, stk_top, loop_pc;
  logic [LVL_W-1:0]  stk_level;
  logic              stk_full, stk_empty, stk_push, stk_pop;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              loop_take;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign br_tgt   = pc_plus1 + ADDR_W'($signed(seq_if.br_off));

`ifdef GSU_PC_LOOP_HW_EN
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d, cnt_dec;
  logic [ADDR_W-1:0] loop_tgt_q, loop_tgt_d;

  assign cnt_dec   = loop_cnt_q - LOOP_W'(1);
  assign loop_take = seq_if.loop_en;
  assign loop_pc   = (cnt_dec != '0) ? loop_tgt_q : pc_plus1;

  // A same-cycle load overrides the decrement of a winning LOOP.
  always_comb begin
    loop_cnt_d = loop_cnt_q;
    loop_tgt_d = loop_tgt_q;
    if (src != SRC_HOLD) begin
      if (seq_if.loop_load) begin
        loop_cnt_d = seq_if.loop_cnt_in;
        loop_tgt_d = seq_if.loop_tgt_in;
      end else if (src == SRC_LOOP) begin
        loop_cnt_d = cnt_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loop_cnt_q <= '0;
      loop_tgt_q <= '0;
    end else begin
      loop_cnt_q <= loop_cnt_d;
      loop_tgt_q <= loop_tgt_d;
    end
  end

  assign seq_if.loop_cnt  = loop_cnt_q;
  assign seq_if.loop_zero = (loop_cnt_q == '0);
`else
  logic unused_loop;

  assign unused_loop      = ^{seq_if.loop_load, seq_if.loop_cnt_in,
                              seq_if.loop_tgt_in, seq_if.loop_en};
  assign loop_take        = 1'b0;
  assign loop_pc          = pc_plus1;
  assign seq_if.loop_cnt  = '0;
  assign seq_if.loop_zero = 1'b1;
`endif

  always_comb begin
    src = SRC_KEEP;
    if      (seq_if.hold)    src = SRC_HOLD;
    else if (seq_if.jmp_en)  src = SRC_JMP;
    else if (seq_if.ret_en)  src = SRC_RET;
    else if (seq_if.call_en) src = SRC_CALL;
    else if (seq_if.br_en)   src = SRC_BR;
    else if (loop_take)      src = SRC_LOOP;
    else if (seq_if.pc_inc)  src = SRC_INC;
  end

  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_JMP:  pc_d = seq_if.jmp_addr;
      SRC_RET:  pc_d = stk_empty ? pc_plus1 : stk_top;
      SRC_CALL: pc_d = seq_if.jmp_addr;
      SRC_BR:   pc_d = br_tgt;
      SRC_LOOP: pc_d = loop_pc;
      SRC_INC:  pc_d = pc_plus1;
      default:  pc_d = pc_q;
    endcase
  end

  assign stk_push = (src == SRC_CALL) && !stk_full;
  assign stk_pop  = (src == SRC_RET) && !stk_empty;

  // A fresh overflow/underflow in the same cycle as err_clr keeps its flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (src != SRC_HOLD) begin
      if (seq_if.err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (src == SRC_CALL && stk_full)  ovf_d = 1'b1;
      if (src == SRC_RET  && stk_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  gsu_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH),
    .LVL_W (LVL_W)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_plus1),
    .top_o   (stk_top),
    .level_o (stk_level),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign seq_if.pc        = pc_q;
  assign seq_if.stk_level = stk_level;
  assign seq_if.stk_ovf   = ovf_q;
  assign seq_if.stk_unf   = unf_q;

endmodule

// File: tb/tb_gsu_pc_sequencer.sv
// Testbench for gsu_pc_sequencer: directed scenarios then random traffic,
// compared against a queue-based behavioural model.
module tb_gsu_pc_sequencer;
  import gsu_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int STACK_DEPTH = 4;
  localparam int LOOP_W      = 16;
  localparam int BR_W        = 8;
  localparam int AMASK       = (1 << ADDR_W) - 1;
  localparam int LMASK       = (1 << LOOP_W) - 1;
`ifdef GSU_PC_LOOP_HW_EN
  localparam bit LOOP_HW = 1'b1;
`else
  localparam bit LOOP_HW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gsu_pc_sequencer_if #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .LOOP_W(LOOP_W), .BR_W(BR_W)
  ) seqIf ();

  gsu_pc_sequencer #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .LOOP_W(LOOP_W), .BR_W(BR_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .seq_if (seqIf)
  );

  int checks = 0;
  int errors = 0;

  int mPc, mOvf, mUnf, mCnt, mTgt;
  int mStk[$];

  task automatic clearInputs();
    reset             = 1'b0;
    seqIf.hold        = 1'b0;
    seqIf.pc_inc      = 1'b0;
    seqIf.jmp_en      = 1'b0;
    seqIf.call_en     = 1'b0;
    seqIf.ret_en      = 1'b0;
    seqIf.jmp_addr    = '0;
    seqIf.br_en       = 1'b0;
    seqIf.br_off      = '0;
    seqIf.loop_load   = 1'b0;
    seqIf.loop_cnt_in = '0;
    seqIf.loop_tgt_in = '0;
    seqIf.loop_en     = 1'b0;
    seqIf.err_clr     = 1'b0;
  endtask

  // Behavioural model: next state from the current inputs, in plain integer arithmetic.
  task automatic modelStep();
    int p1;
    bit evOvf, evUnf;
    if (reset) begin
      mPc = 0; mOvf = 0; mUnf = 0; mCnt = 0; mTgt = 0;
      mStk.delete();
      return;
    end
    if (seqIf.hold) return;
    p1 = (mPc + 1) & AMASK;
    evOvf = 0;
    evUnf = 0;
    if (seqIf.jmp_en) begin
      mPc = int'(seqIf.jmp_addr);
    end else if (seqIf.ret_en) begin
      if (mStk.size() > 0) mPc = mStk.pop_back();
      else begin
        mPc = p1;
        evUnf = 1;
      end
    end else if (seqIf.call_en) begin
      if (mStk.size() < STACK_DEPTH) mStk.push_back(p1);
      else evOvf = 1;
      mPc = int'(seqIf.jmp_addr);
    end else if (seqIf.br_en) begin
      mPc = (mPc + 1 + int'($signed(seqIf.br_off))) & AMASK;
    end else if (LOOP_HW && seqIf.loop_en) begin
      mCnt = (mCnt - 1) & LMASK;
      mPc = (mCnt != 0) ? mTgt : p1;
    end else if (seqIf.pc_inc) begin
      mPc = p1;
    end
    if (seqIf.err_clr) begin
      mOvf = 0;
      mUnf = 0;
    end
    if (evOvf) mOvf = 1;
    if (evUnf) mUnf = 1;
    if (LOOP_HW && seqIf.loop_load) begin
      mCnt = int'(seqIf.loop_cnt_in);
      mTgt = int'(seqIf.loop_tgt_in);
    end
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq($sformatf("%s.pc", tag),        32'(seqIf.pc),        mPc);
    checkEq($sformatf("%s.level", tag),     32'(seqIf.stk_level), mStk.size());
    checkEq($sformatf("%s.ovf", tag),       32'(seqIf.stk_ovf),   mOvf);
    checkEq($sformatf("%s.unf", tag),       32'(seqIf.stk_unf),   mUnf);
    checkEq($sformatf("%s.loop_cnt", tag),  32'(seqIf.loop_cnt),  LOOP_HW ? mCnt : 0);
    checkEq($sformatf("%s.loop_zero", tag), 32'(seqIf.loop_zero),
            (!LOOP_HW || mCnt == 0) ? 1 : 0);
  endtask

  initial begin
    clearInputs();
    mPc = 0; mOvf = 0; mUnf = 0; mCnt = 0; mTgt = 0;

    // Reset state
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset");
    checkEq("reset_pc", 32'(seqIf.pc), 32'h0);

    // Increment and hold
    seqIf.pc_inc = 1'b1;
    repeat (3) applyStimulus();
    checkEq("inc3_pc", 32'(seqIf.pc), 32'h3);
    seqIf.hold = 1'b1;
    repeat (2) applyStimulus();
    checkEq("hold_pc", 32'(seqIf.pc), 32'h3);
    checkOutput("hold");
    clearInputs();

    // Backward branch and increment wrap
    seqIf.jmp_en = 1'b1; seqIf.jmp_addr = 16'h0010;
    applyStimulus();
    clearInputs();
    seqIf.br_en = 1'b1; seqIf.br_off = 8'hFE;
    applyStimulus();
    checkEq("br_back_pc", 32'(seqIf.pc), 32'h000F);
    clearInputs();
    seqIf.jmp_en = 1'b1; seqIf.jmp_addr = 16'hFFFF;
    applyStimulus();
    clearInputs();
    seqIf.pc_inc = 1'b1;
    applyStimulus();
    checkEq("inc_wrap_pc", 32'(seqIf.pc), 32'h0000);
    checkOutput("wrap");
    clearInputs();

    // Call and return
    seqIf.jmp_en = 1'b1; seqIf.jmp_addr = 16'h0100;
    applyStimulus();
    clearInputs();
    seqIf.call_en = 1'b1; seqIf.jmp_addr = 16'h0200;
    applyStimulus();
    checkEq("call_pc", 32'(seqIf.pc), 32'h0200);
    checkEq("call_level", 32'(seqIf.stk_level), 32'h1);
    clearInputs();
    seqIf.ret_en = 1'b1;
    applyStimulus();
    checkEq("ret_pc", 32'(seqIf.pc), 32'h0101);
    checkEq("ret_level", 32'(seqIf.stk_level), 32'h0);
    clearInputs();

    // Overflow, drain, underflow, clear
    seqIf.call_en = 1'b1; seqIf.jmp_addr = 16'h0300;
    repeat (STACK_DEPTH + 1) applyStimulus();
    checkEq("ovf_flag", 32'(seqIf.stk_ovf), 32'h1);
    checkEq("ovf_level", 32'(seqIf.stk_level), STACK_DEPTH);
    clearInputs();
    seqIf.ret_en = 1'b1;
    repeat (STACK_DEPTH) applyStimulus();
    checkEq("drain_pc", 32'(seqIf.pc), 32'h0102);
    checkEq("drain_unf", 32'(seqIf.stk_unf), 32'h0);
    applyStimulus();
    checkEq("unf_flag", 32'(seqIf.stk_unf), 32'h1);
    checkEq("unf_pc", 32'(seqIf.pc), 32'h0103);
    clearInputs();
    seqIf.err_clr = 1'b1;
    applyStimulus();
    checkEq("clr_ovf", 32'(seqIf.stk_ovf), 32'h0);
    checkEq("clr_unf", 32'(seqIf.stk_unf), 32'h0);
    checkOutput("clr");
    clearInputs();

    // Hardware loop
    seqIf.loop_load = 1'b1; seqIf.loop_cnt_in = 16'd3; seqIf.loop_tgt_in = 16'h0040;
    applyStimulus();
    clearInputs();
    seqIf.loop_en = 1'b1;
    applyStimulus();
    checkOutput("loop1");
`ifdef GSU_PC_LOOP_HW_EN
    checkEq("loop1_pc", 32'(seqIf.pc), 32'h0040);
    applyStimulus();
    checkEq("loop2_pc", 32'(seqIf.pc), 32'h0040);
    applyStimulus();
    checkEq("loop3_pc", 32'(seqIf.pc), 32'h0041);
`else
    checkEq("loop1_pc", 32'(seqIf.pc), 32'h0103);
    applyStimulus();
    checkEq("loop2_pc", 32'(seqIf.pc), 32'h0103);
    applyStimulus();
    checkEq("loop3_pc", 32'(seqIf.pc), 32'h0103);
`endif
    checkEq("loop3_zero", 32'(seqIf.loop_zero), 32'h1);
    checkOutput("loop3");
    clearInputs();

    // Jump beats ret and inc; reset in the middle of a loop
    seqIf.call_en = 1'b1; seqIf.jmp_addr = 16'h0500;
    applyStimulus();
    clearInputs();
    seqIf.jmp_en = 1'b1; seqIf.ret_en = 1'b1; seqIf.pc_inc = 1'b1;
    seqIf.jmp_addr = 16'h0777;
    applyStimulus();
    checkEq("prio_pc", 32'(seqIf.pc), 32'h0777);
    checkEq("prio_level", 32'(seqIf.stk_level), 32'h1);
    clearInputs();
    seqIf.loop_load = 1'b1; seqIf.loop_cnt_in = 16'd5; seqIf.loop_tgt_in = 16'h0020;
    applyStimulus();
    clearInputs();
    seqIf.loop_en = 1'b1;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkEq("rst_loop_cnt", 32'(seqIf.loop_cnt), 32'h0);
    checkEq("rst_pc", 32'(seqIf.pc), 32'h0);
    checkOutput("rst_mid");
    clearInputs();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset             = ($urandom_range(0, 63) == 0);
      seqIf.hold        = ($urandom_range(0, 7) == 0);
      seqIf.jmp_en      = ($urandom_range(0, 7) == 0);
      seqIf.ret_en      = ($urandom_range(0, 3) == 0);
      seqIf.call_en     = ($urandom_range(0, 3) == 0);
      seqIf.br_en       = ($urandom_range(0, 4) == 0);
      seqIf.loop_en     = ($urandom_range(0, 2) == 0);
      seqIf.pc_inc      = ($urandom_range(0, 1) == 0);
      seqIf.loop_load   = ($urandom_range(0, 5) == 0);
      seqIf.err_clr     = ($urandom_range(0, 7) == 0);
      seqIf.jmp_addr    = ADDR_W'($urandom);
      seqIf.br_off      = BR_W'($urandom);
      seqIf.loop_cnt_in = LOOP_W'($urandom_range(0, 4));
      seqIf.loop_tgt_in = ADDR_W'($urandom);
      applyStimulus();
      checkOutput("rnd");
    end
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
